// File: rtl/fp_sum_block_lane_unpack_p3_if.sv
// Handshake bundle between the p2 packed-word register, the lane unpacker and the
// downstream fp16 lane consumer.
interface fp_sum_block_lane_unpack_p3_if #(
  parameter int DIN_W  = 32,
  parameter int LANE_W = 16
);
  logic [DIN_W-1:0]  fp16_dout_4_in_pd_d2;
  logic              fp16_dout_4_in_vld_d2;
  logic              fp16_dout_4_in_rdy_d2;
  logic [LANE_W-1:0] fp16_lane_4_pd;
  logic              fp16_lane_4_vld;
  logic              fp16_lane_4_sel;
  logic              fp16_lane_4_rdy;

  // slave: the unpacker itself (takes packed words, produces lanes)
  modport slave (
    input  fp16_dout_4_in_pd_d2,
    input  fp16_dout_4_in_vld_d2,
    output fp16_dout_4_in_rdy_d2,
    output fp16_lane_4_pd,
    output fp16_lane_4_vld,
    output fp16_lane_4_sel,
    input  fp16_lane_4_rdy
  );

  // master: the surrounding pipe (p2 word source plus lane sink)
  modport master (
    output fp16_dout_4_in_pd_d2,
    output fp16_dout_4_in_vld_d2,
    input  fp16_dout_4_in_rdy_d2,
    input  fp16_lane_4_pd,
    input  fp16_lane_4_vld,
    input  fp16_lane_4_sel,
    output fp16_lane_4_rdy
  );
endinterface

// File: rtl/fp_sum_block_lane_unpack_p3.sv
// Splits each packed two-lane fp16 word from p2 into two lane handshakes, low lane
// first, with a registered valid and no bubble between back-to-back words.
//
// state | meaning
// EMPTY | no lane presented (out_vld=0)
// LO    | lane 0 presented, lane 1 parked in hi_buf
// HI    | lane 1 presented, nothing pending
module fp_sum_block_lane_unpack_p3 #(
  parameter int DIN_W  = 32,
  parameter int LANE_W = 16
) (
  input  logic                                nvdla_core_clk,
  input  logic                                nvdla_core_rstn,
  fp_sum_block_lane_unpack_p3_if.slave        bus
);

  generate
    if (DIN_W != 2 * LANE_W) begin : g_bad_width
      $error("DIN_W must equal 2*LANE_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LO    = 2'd1,
    S_HI    = 2'd2
  } state_e;

  logic              out_vld_q, out_vld_d;
  logic              out_sel_q, out_sel_d;
  logic [LANE_W-1:0] out_pd_q,  out_pd_d;
  logic [LANE_W-1:0] hi_buf_q,  hi_buf_d;

  state_e            state;
  logic              in_rdy;
  logic              acc_in;
  logic              acc_out;
  logic [LANE_W-1:0] in_lo;
  logic [LANE_W-1:0] in_hi;

  assign in_lo = bus.fp16_dout_4_in_pd_d2[LANE_W-1:0];
  assign in_hi = bus.fp16_dout_4_in_pd_d2[DIN_W-1:LANE_W];

  always_comb begin
    state = S_EMPTY;
    if (out_vld_q) begin
      state = out_sel_q ? S_HI : S_LO;
    end
  end

  // Ready only when nothing is shown, or lane 1 is leaving this very cycle.
  assign in_rdy  = !out_vld_q || (out_sel_q && bus.fp16_lane_4_rdy);
  assign acc_in  = bus.fp16_dout_4_in_vld_d2 && in_rdy;
  assign acc_out = out_vld_q && bus.fp16_lane_4_rdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      out_vld_q <= 1'b0;
      out_sel_q <= 1'b0;
      out_pd_q  <= '0;
      hi_buf_q  <= '0;
    end else begin
      out_vld_q <= out_vld_d;
      out_sel_q <= out_sel_d;
      out_pd_q  <= out_pd_d;
      hi_buf_q  <= hi_buf_d;
    end
  end

  always_comb begin
    out_vld_d = out_vld_q;
    out_sel_d = out_sel_q;
    out_pd_d  = out_pd_q;
    hi_buf_d  = hi_buf_q;
    case (state)
      S_EMPTY: begin
        if (acc_in) begin
          out_vld_d = 1'b1;
          out_sel_d = 1'b0;
          out_pd_d  = in_lo;
          hi_buf_d  = in_hi;
        end
      end
      S_LO: begin
        if (acc_out) begin
          out_sel_d = 1'b1;
          out_pd_d  = hi_buf_q;
        end
      end
      S_HI: begin
        if (acc_out) begin
          if (acc_in) begin
            out_vld_d = 1'b1;
            out_sel_d = 1'b0;
            out_pd_d  = in_lo;
            hi_buf_d  = in_hi;
          end else begin
            // out_pd keeps the last lane; sel returns to the idle encoding
            out_vld_d = 1'b0;
            out_sel_d = 1'b0;
          end
        end
      end
      default: begin
        out_vld_d = 1'b0;
        out_sel_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    bus.fp16_dout_4_in_rdy_d2 = in_rdy;
    bus.fp16_lane_4_vld       = out_vld_q;
    bus.fp16_lane_4_sel       = out_sel_q;
    bus.fp16_lane_4_pd        = out_pd_q;
  end

endmodule

// File: tb/tb_fp_sum_block_lane_unpack_p3.sv
// Directed and random checks of the lane unpacker against a lane-queue model.
module tb_fp_sum_block_lane_unpack_p3;

  logic nvdla_core_clk  = 1'b0;
  logic nvdla_core_rstn = 1'b0;

  fp_sum_block_lane_unpack_p3_if #(.DIN_W(32), .LANE_W(16)) u_if ();

  fp_sum_block_lane_unpack_p3 #(.DIN_W(32), .LANE_W(16)) u_dut (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .bus             (u_if.slave)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lanes_out;
  int first_pop;
  int last_pop;
  logic [15:0] sb[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One cycle: drive, check at negedge against the lane queue, advance the model, clock.
  task automatic step(input logic v, input logic [31:0] d, input logic lr, output logic acc);
    logic exp_rdy;
    u_if.fp16_dout_4_in_vld_d2 = v;
    u_if.fp16_dout_4_in_pd_d2  = d;
    u_if.fp16_lane_4_rdy       = lr;
    @(negedge nvdla_core_clk);
    exp_rdy = (sb.size() == 0) || (sb.size() == 1 && lr);
    check_eq("in_rdy", {31'd0, u_if.fp16_dout_4_in_rdy_d2}, {31'd0, exp_rdy});
    check_eq("lane_vld", {31'd0, u_if.fp16_lane_4_vld}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      check_eq("lane_pd", {16'd0, u_if.fp16_lane_4_pd}, {16'd0, sb[0]});
      check_eq("lane_sel", {31'd0, u_if.fp16_lane_4_sel}, {31'd0, sb.size() == 1});
    end
    acc = v && exp_rdy;
    if (sb.size() != 0 && lr) begin
      void'(sb.pop_front());
      if (lanes_out == 0) first_pop = cyc;
      last_pop = cyc;
      lanes_out++;
    end
    if (acc) begin
      sb.push_back(d[15:0]);
      sb.push_back(d[31:16]);
    end
    @(posedge nvdla_core_clk);
    #1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   w;
    u_if.fp16_dout_4_in_vld_d2 = 1'b0;
    u_if.fp16_dout_4_in_pd_d2  = '0;
    u_if.fp16_lane_4_rdy       = 1'b0;
    lanes_out = 0;
    first_pop = 0;
    last_pop  = 0;
    repeat (3) @(posedge nvdla_core_clk);
    #1;
    nvdla_core_rstn = 1'b1;

    // reset then idle
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0, 1'b0, acc);
      check_eq("idle_pd", {16'd0, u_if.fp16_lane_4_pd}, 32'h0);
      check_eq("idle_sel", {31'd0, u_if.fp16_lane_4_sel}, 32'h0);
    end

    // single word: 0x4000 then 0x3C00 then idle
    step(1'b1, 32'h3C00_4000, 1'b1, acc);
    check_eq("single_acc", {31'd0, acc}, 32'h1);
    check_eq("single_lo_pd", {16'd0, u_if.fp16_lane_4_pd}, 32'h4000);
    step(1'b0, 32'h0, 1'b1, acc);
    check_eq("single_hi_pd", {16'd0, u_if.fp16_lane_4_pd}, 32'h3C00);
    check_eq("single_hi_sel", {31'd0, u_if.fp16_lane_4_sel}, 32'h1);
    step(1'b0, 32'h0, 1'b1, acc);
    step(1'b0, 32'h0, 1'b1, acc);

    // streaming: 8 words, 16 lanes with no bubble
    lanes_out = 0;
    w = 0;
    for (int c = 0; c < 40 && (w < 8 || sb.size() != 0); c++) begin
      step(w < 8, {16'(2 * w + 1), 16'(2 * w)}, 1'b1, acc);
      if (acc) w++;
    end
    check_eq("stream_words", w, 8);
    check_eq("stream_lanes", lanes_out, 16);
    check_eq("stream_nobubble", last_pop - first_pop, 15);

    // back-pressure in LO then in HI
    step(1'b1, 32'hFC00_7E01, 1'b0, acc);
    check_eq("bp_acc", {31'd0, acc}, 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1111_2222, 1'b0, acc);
    step(1'b1, 32'h1111_2222, 1'b1, acc);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h1111_2222, 1'b0, acc);
    check_eq("bp_hi_pd", {16'd0, u_if.fp16_lane_4_pd}, 32'hFC00);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, acc);

    // random stress
    lanes_out = 0;
    w = 0;
    for (int c = 0; c < 40000 && (w < 3000 || sb.size() != 0); c++) begin
      step((w < 3000) && ($urandom_range(0, 1) == 1), $urandom, $urandom_range(0, 1) == 1, acc);
      if (acc) w++;
    end
    check_eq("rand_words", w, 3000);
    check_eq("rand_lanes", lanes_out, 6000);

    // reset while lane 1 (0xABCD) is parked
    step(1'b1, 32'hABCD_1234, 1'b0, acc);
    u_if.fp16_dout_4_in_vld_d2 = 1'b0;
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    check_eq("rst_vld", {31'd0, u_if.fp16_lane_4_vld}, 32'h0);
    check_eq("rst_rdy", {31'd0, u_if.fp16_dout_4_in_rdy_d2}, 32'h1);
    check_eq("rst_pd", {16'd0, u_if.fp16_lane_4_pd}, 32'h0);
    sb.delete();
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    @(posedge nvdla_core_clk);
    #1;
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, acc);
    step(1'b1, 32'h5678_9ABC, 1'b1, acc);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, acc);
    check_eq("post_rst_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
